// File: rtl/rob_commit_if.sv
// ============================================================================
// rob_commit_if : ROB-head / writeback / store / flush / BHT signals of the retire stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface rob_commit_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
);
   logic                  rob_empty;
   logic                  rob_valid;
   logic [3:0]            rob_inst;
   logic [2:0]            rob_dest;
   logic [DATA_WIDTH-1:0] rob_value;
   logic                  rob_predict;
   logic [15:0]           rob_orig_pc;
   logic [3:0]            rob_bht;
   logic                  store_ack;

   logic                  rob_re;
   logic                  reg_ld;
   logic [2:0]            reg_dest;
   logic [DATA_WIDTH-1:0] reg_value;
   logic                  store_commit;
   logic                  flush;
   logic [15:0]           pc_redirect;
   logic                  bht_ld;
   logic [15:0]           bht_pc;
   logic [3:0]            bht_new;
   logic [CNT_WIDTH-1:0]  retire_count;
   logic [CNT_WIDTH-1:0]  mispredict_count;

   modport master (
      output rob_empty, rob_valid, rob_inst, rob_dest, rob_value,
             rob_predict, rob_orig_pc, rob_bht, store_ack,
      input  rob_re, reg_ld, reg_dest, reg_value, store_commit, flush,
             pc_redirect, bht_ld, bht_pc, bht_new, retire_count, mispredict_count
   );

   modport slave (
      input  rob_empty, rob_valid, rob_inst, rob_dest, rob_value,
             rob_predict, rob_orig_pc, rob_bht, store_ack,
      output rob_re, reg_ld, reg_dest, reg_value, store_commit, flush,
             pc_redirect, bht_ld, bht_pc, bht_new, retire_count, mispredict_count
   );
endinterface

`default_nettype wire

// File: rtl/rob_commit_unit.sv
// ============================================================================
// rob_commit_unit : in-order retire of the ROB head with store handshake and mispredict flush
// Rev 1.0
// ============================================================================
`default_nettype none

module rob_commit_unit #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  wire logic     clk,
   input  wire logic     reset_n,
   rob_commit_if.slave   bus
);

   localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FCW-1:0] c_FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

   localparam logic [3:0] c_OP_BR   = 4'd0;
   localparam logic [3:0] c_OP_ADD  = 4'd1;
   localparam logic [3:0] c_OP_LDB  = 4'd2;
   localparam logic [3:0] c_OP_STB  = 4'd3;
   localparam logic [3:0] c_OP_JSR  = 4'd4;
   localparam logic [3:0] c_OP_AND  = 4'd5;
   localparam logic [3:0] c_OP_LDR  = 4'd6;
   localparam logic [3:0] c_OP_STW  = 4'd7;
   localparam logic [3:0] c_OP_NOT  = 4'd9;
   localparam logic [3:0] c_OP_LDI  = 4'd10;
   localparam logic [3:0] c_OP_STI  = 4'd11;
   localparam logic [3:0] c_OP_SHF  = 4'd13;
   localparam logic [3:0] c_OP_LEA  = 4'd14;
   localparam logic [3:0] c_OP_TRAP = 4'd15;

   typedef enum logic [1:0] {
      S_COMMIT     = 2'd0,
      S_STORE_WAIT = 2'd1,
      S_FLUSH      = 2'd2
   } state_t;

   state_t               r_state;
   logic [FCW-1:0]       r_flush_cnt;
   logic                 r_flush;
   logic [15:0]          r_pc_redirect;
   logic [CNT_WIDTH-1:0] r_retire_count;
   logic [CNT_WIDTH-1:0] r_mispredict_count;

   logic        w_ready;
   logic        w_is_br;
   logic        w_is_store;
   logic        w_writes_reg;
   logic [15:0] w_next_pc;
   logic        w_taken;
   logic        w_mispredict;
   logic        w_rob_re;
   logic        w_reg_ld;
   logic        w_store_commit;
   logic        w_bht_ld;

   assign w_ready   = !bus.rob_empty && bus.rob_valid;
   assign w_next_pc = 16'(bus.rob_value);
   assign w_taken   = (w_next_pc != (bus.rob_orig_pc + 16'd2));

   always_comb begin
      w_is_br      = 1'b0;
      w_is_store   = 1'b0;
      w_writes_reg = 1'b0;
      unique case (bus.rob_inst)
         c_OP_BR:                       w_is_br      = 1'b1;
         c_OP_STB, c_OP_STW, c_OP_STI:  w_is_store   = 1'b1;
         c_OP_ADD, c_OP_AND, c_OP_NOT,
         c_OP_LDB, c_OP_LDR, c_OP_LDI,
         c_OP_LEA, c_OP_SHF,
         c_OP_JSR, c_OP_TRAP:           w_writes_reg = 1'b1;
         default:                       ;
      endcase
   end

   // Strobes are forced low during reset regardless of the head contents.
   always_comb begin
      w_rob_re       = 1'b0;
      w_reg_ld       = 1'b0;
      w_store_commit = 1'b0;
      w_bht_ld       = 1'b0;
      if (reset_n) begin
         unique case (r_state)
            S_COMMIT: begin
               if (w_ready) begin
                  if (w_is_store) begin
                     w_store_commit = 1'b1;
                  end else begin
                     w_rob_re = 1'b1;
                     w_reg_ld = w_writes_reg;
                     w_bht_ld = w_is_br;
                  end
               end
            end
            S_STORE_WAIT: w_rob_re = bus.store_ack;
            default:      ;
         endcase
      end
   end

   assign w_mispredict = w_bht_ld && (w_taken != bus.rob_predict);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state            <= S_COMMIT;
         r_flush_cnt        <= '0;
         r_flush            <= 1'b0;
         r_pc_redirect      <= 16'd0;
         r_retire_count     <= '0;
         r_mispredict_count <= '0;
      end else begin
         if (w_rob_re) r_retire_count <= r_retire_count + 1'b1;
         unique case (r_state)
            S_COMMIT: begin
               if (w_mispredict) begin
                  r_mispredict_count <= r_mispredict_count + 1'b1;
                  r_flush            <= 1'b1;
                  r_pc_redirect      <= w_next_pc;
                  r_flush_cnt        <= c_FLUSH_LOAD;
                  r_state            <= S_FLUSH;
               end else if (w_store_commit) begin
                  r_state <= S_STORE_WAIT;
               end
            end
            // The ack is only honoured here, never in the cycle the store is released.
            S_STORE_WAIT: begin
               if (bus.store_ack) r_state <= S_COMMIT;
            end
            S_FLUSH: begin
               if (r_flush_cnt == '0) begin
                  r_flush <= 1'b0;
                  r_state <= S_COMMIT;
               end else begin
                  r_flush_cnt <= r_flush_cnt - 1'b1;
               end
            end
            default: r_state <= S_COMMIT;
         endcase
      end
   end

   assign bus.rob_re           = w_rob_re;
   assign bus.reg_ld           = w_reg_ld;
   assign bus.reg_dest         = bus.rob_dest;
   assign bus.reg_value        = bus.rob_value;
   assign bus.store_commit     = w_store_commit;
   assign bus.flush            = r_flush;
   assign bus.pc_redirect      = r_pc_redirect;
   assign bus.bht_ld           = w_bht_ld;
   assign bus.bht_pc           = bus.rob_orig_pc;
   assign bus.bht_new          = {bus.rob_bht[2:0], w_taken};
   assign bus.retire_count     = r_retire_count;
   assign bus.mispredict_count = r_mispredict_count;

endmodule

`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
// ============================================================================
// tb_rob_commit_unit : directed scenarios plus randomized run against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rob_commit_unit;

   localparam int FC = 2;
   localparam int CW = 4;

   logic clk     = 1'b0;
   logic clk_en  = 1'b1;
   logic reset_n = 1'b0;

   int checks = 0;
   int errors = 0;

   // behavioural model: phase 0 = retiring, 1 = waiting for store ack, 2 = flushing
   int          m_phase;
   int          m_flush_left;
   int          m_retire;
   int          m_mis;
   logic [15:0] m_pc_redirect;

   rob_commit_if #(.DATA_WIDTH(16), .CNT_WIDTH(CW)) bus ();

   rob_commit_unit #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   function automatic logic [3:0] strobes();
      return {bus.rob_re, bus.reg_ld, bus.store_commit, bus.bht_ld};
   endfunction

   task automatic set_head(input logic e, input logic v, input logic [3:0] op, input logic [2:0] d,
                           input logic [15:0] val, input logic p, input logic [15:0] pc,
                           input logic [3:0] h);
      bus.rob_empty   = e;
      bus.rob_valid   = v;
      bus.rob_inst    = op;
      bus.rob_dest    = d;
      bus.rob_value   = val;
      bus.rob_predict = p;
      bus.rob_orig_pc = pc;
      bus.rob_bht     = h;
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      bus.store_ack = 1'b0;
      set_head(1'b1, 1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 16'd0, 4'd0);
      m_phase = 0; m_flush_left = 0; m_retire = 0; m_mis = 0; m_pc_redirect = 16'd0;
      #2;
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      bus.store_ack = 1'b0;
      set_head(1'b0, 1'b1, 4'd1, 3'd1, 16'h0055, 1'b0, 16'h0000, 4'd0);
      #1;
      checks++;
      if (strobes() !== 4'b0000) begin errors++; $display("FAIL reset_strobes got=%b want=0000", strobes()); end
      checks++;
      if (bus.flush !== 1'b0 || bus.pc_redirect !== 16'd0) begin
         errors++; $display("FAIL reset_flush got flush=%b pc=%h want 0/0000", bus.flush, bus.pc_redirect);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.retire_count !== 4'd0 || bus.mispredict_count !== 4'd0 || strobes() !== 4'b0000) begin
         errors++; $display("FAIL reset_hold got ret=%0d mis=%0d str=%b want 0/0/0000",
                            bus.retire_count, bus.mispredict_count, strobes());
      end
      set_head(1'b1, 1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 16'd0, 4'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add_back_to_back();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_head(1'b0, 1'b1, 4'd1, 3'(k + 1), 16'(16'h0011 * (k + 1)), 1'b0, 16'h0100, 4'd0);
         #1;
         checks++;
         if (strobes() !== 4'b1100 || bus.reg_dest !== 3'(k + 1) || bus.reg_value !== 16'(16'h0011 * (k + 1))) begin
            errors++; $display("FAIL add_b2b[%0d] got str=%b dest=%0d val=%h want 1100/%0d/%h",
                               k, strobes(), bus.reg_dest, bus.reg_value, k + 1, 16'h0011 * (k + 1));
         end
         @(posedge clk); #1;
      end
      set_head(1'b1, 1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 16'd0, 4'd0);
      #1;
      checks++;
      if (bus.retire_count !== 4'd3) begin errors++; $display("FAIL add_count got=%0d want=3", bus.retire_count); end
   endtask

   task automatic test_not_valid();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         set_head(1'b0, 1'b0, 4'd5, 3'd4, 16'h00AA, 1'b0, 16'h0200, 4'd0);
         #1;
         checks++;
         if (strobes() !== 4'b0000) begin errors++; $display("FAIL notvalid[%0d] got=%b want=0000", k, strobes()); end
         @(posedge clk); #1;
      end
      set_head(1'b0, 1'b1, 4'd5, 3'd4, 16'h00AA, 1'b0, 16'h0200, 4'd0);
      #1;
      checks++;
      if (strobes() !== 4'b1100) begin errors++; $display("FAIL valid_rise got=%b want=1100", strobes()); end
      @(posedge clk); #1;
      set_head(1'b1, 1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 16'd0, 4'd0);
      checks++;
      if (bus.retire_count !== 4'd1) begin errors++; $display("FAIL notvalid_count got=%0d want=1", bus.retire_count); end
   endtask

   task automatic test_store();
      do_reset();
      set_head(1'b0, 1'b1, 4'd7, 3'd0, 16'h1234, 1'b0, 16'h0300, 4'd0);
      bus.store_ack = 1'b1;
      #1;
      checks++;
      if (strobes() !== 4'b0010) begin errors++; $display("FAIL store_release got=%b want=0010", strobes()); end
      @(posedge clk); #1;
      bus.store_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (strobes() !== 4'b0000) begin errors++; $display("FAIL store_wait[%0d] got=%b want=0000", k, strobes()); end
         @(posedge clk); #1;
      end
      bus.store_ack = 1'b1;
      #1;
      checks++;
      if (strobes() !== 4'b1000) begin errors++; $display("FAIL store_ack got=%b want=1000", strobes()); end
      @(posedge clk); #1;
      bus.store_ack = 1'b0;
      set_head(1'b0, 1'b1, 4'd1, 3'd2, 16'h0042, 1'b0, 16'h0302, 4'd0);
      #1;
      checks++;
      if (strobes() !== 4'b1100 || bus.retire_count !== 4'd1) begin
         errors++; $display("FAIL store_return got str=%b ret=%0d want 1100/1", strobes(), bus.retire_count);
      end
      @(posedge clk); #1;
      set_head(1'b1, 1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 16'd0, 4'd0);
   endtask

   task automatic test_br_mispredict();
      do_reset();
      set_head(1'b0, 1'b1, 4'd0, 3'd0, 16'h3040, 1'b0, 16'h3000, 4'b0101);
      #1;
      checks++;
      if (strobes() !== 4'b1001 || bus.bht_pc !== 16'h3000 || bus.bht_new !== 4'b1011) begin
         errors++; $display("FAIL br_mis_bht got str=%b pc=%h new=%b want 1001/3000/1011",
                            strobes(), bus.bht_pc, bus.bht_new);
      end
      @(posedge clk); #1;
      set_head(1'b0, 1'b1, 4'd1, 3'd1, 16'h0077, 1'b0, 16'h3040, 4'd0);
      for (int k = 0; k < FC; k++) begin
         #1;
         checks++;
         if (bus.flush !== 1'b1 || bus.pc_redirect !== 16'h3040 || strobes() !== 4'b0000) begin
            errors++; $display("FAIL br_flush[%0d] got flush=%b pc=%h str=%b want 1/3040/0000",
                               k, bus.flush, bus.pc_redirect, strobes());
         end
         @(posedge clk); #1;
      end
      checks++;
      if (bus.flush !== 1'b0 || strobes() !== 4'b1100 || bus.mispredict_count !== 4'd1 || bus.retire_count !== 4'd1) begin
         errors++; $display("FAIL br_after got flush=%b str=%b mis=%0d ret=%0d want 0/1100/1/1",
                            bus.flush, strobes(), bus.mispredict_count, bus.retire_count);
      end
      @(posedge clk); #1;
      set_head(1'b1, 1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 16'd0, 4'd0);
   endtask

   task automatic test_br_correct();
      do_reset();
      set_head(1'b0, 1'b1, 4'd0, 3'd0, 16'h0000, 1'b0, 16'hFFFE, 4'b1010);
      #1;
      checks++;
      if (strobes() !== 4'b1001 || bus.bht_new !== 4'b0100) begin
         errors++; $display("FAIL br_wrap got str=%b new=%b want 1001/0100", strobes(), bus.bht_new);
      end
      @(posedge clk); #1;
      set_head(1'b0, 1'b1, 4'd0, 3'd0, 16'h2000, 1'b1, 16'h1000, 4'b0011);
      #1;
      checks++;
      if (bus.flush !== 1'b0 || strobes() !== 4'b1001 || bus.bht_new !== 4'b0111) begin
         errors++; $display("FAIL br_taken_b2b got flush=%b str=%b new=%b want 0/1001/0111",
                            bus.flush, strobes(), bus.bht_new);
      end
      @(posedge clk); #1;
      set_head(1'b1, 1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 16'd0, 4'd0);
      #1;
      checks++;
      if (bus.flush !== 1'b0 || bus.mispredict_count !== 4'd0 || bus.retire_count !== 4'd2) begin
         errors++; $display("FAIL br_correct_counts got flush=%b mis=%0d ret=%0d want 0/0/2",
                            bus.flush, bus.mispredict_count, bus.retire_count);
      end
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      set_head(1'b0, 1'b1, 4'd0, 3'd0, 16'h4444, 1'b0, 16'h4000, 4'd0);
      @(posedge clk); #1;
      set_head(1'b0, 1'b1, 4'd1, 3'd1, 16'h0001, 1'b0, 16'h0000, 4'd0);
      clk_en = 1'b0;
      #1;
      checks++;
      if (bus.flush !== 1'b1) begin errors++; $display("FAIL midflush_pre got flush=%b want 1", bus.flush); end
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.flush !== 1'b0 || bus.pc_redirect !== 16'd0 || bus.retire_count !== 4'd0 ||
          bus.mispredict_count !== 4'd0 || strobes() !== 4'b0000) begin
         errors++; $display("FAIL midflush_reset got flush=%b pc=%h ret=%0d mis=%0d str=%b want 0/0000/0/0/0000",
                            bus.flush, bus.pc_redirect, bus.retire_count, bus.mispredict_count, strobes());
      end
      #3;
      reset_n = 1'b1;
      #1;
      checks++;
      if (strobes() !== 4'b1100) begin errors++; $display("FAIL midflush_resume got str=%b want 1100", strobes()); end
      set_head(1'b1, 1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 16'd0, 4'd0);
      clk_en = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic        e, v, p, ack, rdy, is_br, is_st, wr, tk;
      logic [3:0]  op, h, exp_str;
      logic [2:0]  d;
      logic [15:0] pc, val, seq_pc;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         e   = ($urandom_range(0, 4) == 0);
         v   = ($urandom_range(0, 3) != 0);
         ack = ($urandom_range(0, 2) == 0);
         op  = 4'($urandom_range(0, 15));
         d   = 3'($urandom);
         p   = 1'($urandom);
         h   = 4'($urandom);
         pc  = 16'($urandom);
         seq_pc = pc + 16'd2;
         val = ($urandom_range(0, 1) == 0) ? seq_pc : 16'($urandom);
         set_head(e, v, op, d, val, p, pc, h);
         bus.store_ack = ack;
         #1;
         rdy   = !e && v;
         is_br = (op == 4'd0);
         is_st = (op == 4'd3) || (op == 4'd7) || (op == 4'd11);
         wr    = !is_br && !is_st && (op != 4'd8) && (op != 4'd12);
         tk    = (val != seq_pc);
         exp_str = 4'b0000;
         if (m_phase == 0 && rdy) exp_str = is_st ? 4'b0010 : {1'b1, wr, 1'b0, is_br};
         if (m_phase == 1 && ack) exp_str = 4'b1000;
         checks++;
         if (strobes() !== exp_str) begin
            errors++; $display("FAIL rnd_strobes[%0d] got=%b want=%b op=%0d", i, strobes(), exp_str, op);
         end
         checks++;
         if ((bus.reg_ld && (bus.reg_dest !== d || bus.reg_value !== val)) ||
             (bus.bht_ld && (bus.bht_pc !== pc || bus.bht_new !== {h[2:0], tk}))) begin
            errors++; $display("FAIL rnd_data[%0d] got dest=%0d val=%h bpc=%h bnew=%b want %0d/%h/%h/%b",
                               i, bus.reg_dest, bus.reg_value, bus.bht_pc, bus.bht_new, d, val, pc, {h[2:0], tk});
         end
         checks++;
         if (bus.flush !== (m_phase == 2) || (m_phase == 2 && bus.pc_redirect !== m_pc_redirect) ||
             bus.retire_count !== 4'(m_retire) || bus.mispredict_count !== 4'(m_mis)) begin
            errors++; $display("FAIL rnd_state[%0d] got flush=%b pc=%h ret=%0d mis=%0d want %0d/%h/%0d/%0d",
                               i, bus.flush, bus.pc_redirect, bus.retire_count, bus.mispredict_count,
                               m_phase == 2, m_pc_redirect, m_retire % 16, m_mis % 16);
         end
         case (m_phase)
            0: if (rdy) begin
                  if (is_st) m_phase = 1;
                  else begin
                     m_retire++;
                     if (is_br && tk != p) begin
                        m_mis++;
                        m_pc_redirect = val;
                        m_flush_left  = FC;
                        m_phase       = 2;
                     end
                  end
               end
            1: if (ack) begin m_retire++; m_phase = 0; end
            default: begin
               m_flush_left--;
               if (m_flush_left == 0) m_phase = 0;
            end
         endcase
         @(posedge clk); #1;
      end
      bus.store_ack = 1'b0;
      set_head(1'b1, 1'b0, 4'd0, 3'd0, 16'd0, 1'b0, 16'd0, 4'd0);
   endtask

   initial begin
      test_reset();
      test_add_back_to_back();
      test_not_valid();
      test_store();
      test_br_mispredict();
      test_br_correct();
      test_reset_mid_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Retire stage directly downstream of the reorder buffer.
- Each cycle it examines the ROB head. When the entry is complete, it retires it in program order: register-file writeback, store release to the memory stage, and branch resolution.
- On a branch mispredict it drives a multi-cycle pipeline flush and a PC redirect to fetch.
- Also produces BHT update traffic and retire/mispredict performance counters.

Parameters:
- data_width, 16, width of ROB value field and register data
- flush_cycles, 2, cycles flush stays asserted after a mispredict (>=1)
- cnt_width, 16, width of performance counters

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rob_empty  input  1  ROB empty flag
- rob_valid  input  1  head entry's value has arrived on CDB
- rob_inst  input  4  head opcode (lc3b_opcode)
- rob_dest  input  3  head destination register (lc3b_reg)
- rob_value  input  data_width  head result; for BR, the resolved next PC
- rob_predict  input  1  head predicted-taken bit
- rob_orig_pc  input  16  PC of head instruction (lc3b_word)
- rob_bht  input  4  BHT history snapshot at fetch
- store_ack  input  1  memory stage finished the released store
- rob_re  output  1  pop ROB head this cycle
- reg_ld  output  1  register-file write enable
- reg_dest  output  3  register-file write address
- reg_value  output  data_width  register-file write data
- store_commit  output  1  release head store to memory
- flush  output  1  pipeline flush
- pc_redirect  output  16  corrected fetch PC, valid while flush=1
- bht_ld  output  1  BHT update strobe
- bht_pc  output  16  PC indexing the BHT entry
- bht_new  output  4  updated history
- retire_count  output  cnt_width  instructions retired
- mispredict_count  output  cnt_width  mispredicts

Behaviour:
- Reset (asynchronous, reset_n=0): state=COMMIT; flush=0; pc_redirect=0; both counters=0. rob_re, reg_ld, store_commit and bht_ld evaluate to 0 because state=COMMIT and they are gated while reset_n=0.
- Reset mid-operation aborts any FLUSH or STORE_WAIT immediately, with no pending store re-release.
- States: COMMIT, STORE_WAIT, FLUSH.
- COMMIT, ready condition: ready = !rob_empty & rob_valid. If ready is 0, all strobes are 0.
- COMMIT, ready and ALU/load/LEA/SHF/JSR/JMP/TRAP op:
  - rob_re=1 combinationally in the same cycle.
  - Register-writing opcodes (ADD, AND, NOT, LDB, LDW, LDI, LDR, LEA, SHF, JSR, TRAP) also assert reg_ld=1, reg_dest=rob_dest, reg_value=rob_value in the same cycle.
  - JSR and TRAP write the R7 value carried in rob_dest/rob_value; no remapping is done here.
  - State stays COMMIT; retire_count increments.
- COMMIT, ready and STB/STW/STI:
  - store_commit=1 for one cycle, with no rob_re.
  - Next state is STORE_WAIT.
- STORE_WAIT:
  - store_commit=0.
  - On store_ack: rob_re=1 in that cycle, retire_count increments, next state COMMIT.
  - A store_ack that arrives in the same cycle as store_commit is ignored; it must be sampled in STORE_WAIT.
- COMMIT, ready and BR:
  - taken = (rob_value != rob_orig_pc + 2), 16-bit wrap.
  - rob_re=1, bht_ld=1, bht_pc=rob_orig_pc, bht_new={rob_bht[2:0], taken}; retire_count increments.
  - If taken != rob_predict: mispredict_count increments; at the next edge flush<=1, pc_redirect<=rob_value, state<=FLUSH with an internal counter loaded to flush_cycles-1.
- FLUSH:
  - flush=1 and all strobes=0.
  - The counter decrements each cycle; at 0, next state is COMMIT and flush<=0.
  - flush is high for exactly flush_cycles cycles.
  - The ROB is cleared externally by flush, so the head is not examined.
- Counters wrap modulo 2^cnt_width.
- A correctly predicted BR causes no flush and allows back-to-back retirement.
- Throughput: at most one retirement per cycle.
- Unknown or reserved opcode: retired like an ALU op without reg_ld.

Test Plan:
- Reset mid-FLUSH: reset_n low during FLUSH -> flush=0 and counters=0 immediately, while clk is held stopped.
- ADD back-to-back: 3 valid heads (dest 1/2/3, values 0x0011/0x0022/0x0033) -> rob_re and reg_ld high for 3 consecutive cycles with matching dest/value; retire_count=3.
- Head not valid: rob_empty=0, rob_valid=0 for 5 cycles, then 1 -> no strobes until rob_valid rises; retire happens that cycle.
- STW with store_ack delayed 4 cycles -> store_commit pulses once; rob_re asserts only in the store_ack cycle; state returns to COMMIT.
- BR mispredict: orig_pc=0x3000, value=0x3040, predict=0, bht=4'b0101 -> bht_ld with bht_new=4'b1011; next 2 cycles flush=1 with pc_redirect=0x3040; mispredict_count=1; no retirements during flush.
- BR correct not-taken: orig_pc=0xFFFE, value=0x0000 (wrap), predict=0 -> taken=0, no flush, bht_new={bht[2:0],0}.
